e_muldiv_unit: RTL

//  E-stage multiply/divide unit; consumes the operands and control word latched by the ID/EX register.

---
 rtl/e_muldiv_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div with architectural HI/LO,
// mfhi/mflo read port, mthi/mtlo writes and the D-stage stall request.
module e_muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        DIsMD,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut,
    output logic        MDStall
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e      state;
    logic [3:0]  cnt;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        skip_commit;

    logic        is_start_op;
    logic        is_mult_op;
    logic        signed_op;
    logic        start;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    // Division runs on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        is_start_op = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
        is_mult_op  = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
        signed_op   = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        start       = is_start_op & ~Busy & ~Req;

        a_ext   = {{32{signed_op & A[31]}}, A};
        b_ext   = {{32{signed_op & B[31]}}, B};
        product = a_ext * b_ext;

        a_neg       = signed_op & A[31];
        b_neg       = signed_op & B[31];
        div_by_zero = ~is_mult_op & (B == '0);
        a_mag       = a_neg ? (32'd0 - A) : A;
        b_mag       = (B == '0) ? 32'd1 : (b_neg ? (32'd0 - B) : B);
        q_mag       = a_mag / b_mag;
        r_mag       = a_mag % b_mag;
        quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem         = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            Busy        <= 1'b0;
            cnt         <= '0;
            hi_n        <= '0;
            lo_n        <= '0;
            skip_commit <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_BUSY;
                        Busy        <= 1'b1;
                        cnt         <= is_mult_op ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        hi_n        <= is_mult_op ? product[63:32] : rem;
                        lo_n        <= is_mult_op ? product[31:0]  : quot;
                        skip_commit <= div_by_zero;
                    end else if (~Req) begin
                        if (MDOp == OP_MTHI) HI <= A;
                        if (MDOp == OP_MTLO) LO <= A;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!skip_commit) begin
                            HI <= hi_n;
                            LO <= lo_n;
                        end
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        MDOut = '0;
        if (MDOp == OP_MFHI) MDOut = HI;
        else if (MDOp == OP_MFLO) MDOut = LO;
    end

    assign MDStall = DIsMD & (start | Busy);

endmodule
